led_7seg_scan: RTL and testbench

- Display-side stage directly downstream of the 7-segment output register.
- Consumes its 32-bit segment word (4 digits × 8 segment bits: bit0=a … bit6=g, bit7=dp, active-high) and drives a multiplexed common-anode display.
- Provides time-division digit scanning, an anti-ghost blanking gap at each digit slot, 4-bit PWM brightness, and a frame-synchronous shadow latch so that CPU writes never tear a frame.

---
 rtl/led_7seg_scan.sv | 93 +++++++++
 tb/tb_led_7seg_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/led_7seg_scan.sv
// Multiplexed common-anode 7-segment driver: digit scan, blanking gap, 4-bit PWM, frame-synchronous shadow latch.
// Latency: outputs registered one cycle after the counter state that selects them; shadow reloads only at frame boundaries.
// Backpressure: none; enable=0 holds the display dark and keeps the shadow following data_in.
module led_7seg_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       data_in,
    input  logic              enable,
    input  logic [3:0]        brightness,
    output logic [7:0]        seg_n,
    output logic [DIGITS-1:0] dig_n,
    output logic              frame_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     pcnt, pcnt_nxt;
    logic [DW-1:0]     digit, digit_nxt;
    logic [3:0]        pwm, pwm_nxt;
    logic [31:0]       shadow, shadow_nxt;
    logic              tick_nxt;
    logic              pcnt_end, digit_end;
    logic              lit;
    logic [7:0]        seg_sel;
    logic [DIGITS-1:0] dig_sel;

    assign pcnt_end  = (pcnt == PW'(PRESCALE - 1));
    assign digit_end = (digit == DW'(DIGITS - 1));

    // Gating with enable keeps the display dark on the very cycle scanning stops.
    assign lit = enable && (pcnt >= PW'(BLANK)) && (pwm < brightness);

    assign seg_sel = shadow[{digit, 3'b000} +: 8];

    always_comb begin
        dig_sel        = '0;
        dig_sel[digit] = 1'b1;
    end

    always_comb begin
        pcnt_nxt   = '0;
        digit_nxt  = '0;
        pwm_nxt    = '0;
        shadow_nxt = shadow;
        tick_nxt   = 1'b0;
        if (enable) begin
            if (pcnt_end) begin
                digit_nxt = digit_end ? '0 : digit + 1'b1;
                if (digit_end) begin
                    shadow_nxt = data_in;
                    tick_nxt   = 1'b1;
                end
            end else begin
                pcnt_nxt  = pcnt + 1'b1;
                digit_nxt = digit;
                pwm_nxt   = pwm + 1'b1;
            end
        end else begin
            shadow_nxt = data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt       <= '0;
            digit      <= '0;
            pwm        <= '0;
            shadow     <= '0;
            seg_n      <= 8'hFF;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            pcnt       <= pcnt_nxt;
            digit      <= digit_nxt;
            pwm        <= pwm_nxt;
            shadow     <= shadow_nxt;
            frame_tick <= tick_nxt;
            if (lit) begin
                seg_n <= ~seg_sel;
                dig_n <= ~dig_sel;
            end else begin
                seg_n <= 8'hFF;
                dig_n <= '1;
            end
        end
    end

endmodule

// File: tb/tb_led_7seg_scan.sv
// Directed bench for led_7seg_scan at PRESCALE=32, BLANK=4, DIGITS=4; outputs sampled on the falling edge.
module tb_led_7seg_scan;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        enable = 1'b0;
    logic [3:0]  brightness = 4'h0;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int nlit, ntick, nblank, nseg;
    int slot_lit [4];

    led_7seg_scan #(.DIGITS(4), .PRESCALE(32), .BLANK(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .enable     (enable),
        .brightness (brightness),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        brightness = 4'd15;
        data_in    = 32'h4F5B063F;
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(seg_n), 32'hFF);
        chk("reset_dig", 32'(dig_n), 32'hF);
        chk("reset_tick", 32'(frame_tick), 32'h0);

        // Edge i after enable carries state pcnt=i%32, digit=(i/32)%4, pwm=pcnt%16.
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        nlit = 0; ntick = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (seg_n !== 8'hFF) nlit++;
            if (frame_tick === 1'b1) ntick++;
            if (i == 127) chk("f1_tick_at_128", 32'(frame_tick), 32'h1);
        end
        chk("f1_segs_dark", 32'(nlit), 32'd0);
        chk("f1_single_tick", 32'(ntick), 32'd1);

        nlit = 0; nblank = 0;
        for (int i = 128; i < 256; i++) begin
            @(negedge clk);
            if ((i % 32) < 4 && (dig_n !== 4'hF || seg_n !== 8'hFF)) nblank++;
            if (i < 160 && dig_n !== 4'hF) nlit++;
            if (i == 132) begin
                chk("f2_d0_dig", 32'(dig_n), 32'hE);
                chk("f2_d0_seg", 32'(seg_n), 32'hC0);
            end
            if (i == 143) chk("f2_pwm15_dark", 32'(dig_n), 32'hF);
            if (i == 229) begin
                chk("f2_d3_dig", 32'(dig_n), 32'h7);
                chk("f2_d3_seg", 32'(seg_n), 32'hB0);
            end
            if (i == 240) data_in = 32'hFFFFFFFF;
            if (i == 250) chk("f2_no_tear", 32'(seg_n), 32'hB0);
            if (i == 255) begin
                chk("f2_tick", 32'(frame_tick), 32'h1);
                brightness = 4'd4;
            end
        end
        chk("f2_blank_window", 32'(nblank), 32'd0);
        chk("f2_slot0_lit", 32'(nlit), 32'd26);

        for (int s = 0; s < 4; s++) slot_lit[s] = 0;
        nseg = 0;
        for (int i = 256; i < 384; i++) begin
            @(negedge clk);
            if (dig_n !== 4'hF) begin
                slot_lit[(i - 256) / 32]++;
                if (seg_n !== 8'h00) nseg++;
            end
            if (i == 272) begin
                chk("f3_pwm0_dig", 32'(dig_n), 32'hE);
                chk("f3_pwm0_seg", 32'(seg_n), 32'h00);
            end
            if (i == 276) chk("f3_pwm4_dark", 32'(dig_n), 32'hF);
            if (i == 300) data_in = 32'h00000000;
            if (i == 383) begin
                chk("f3_tick", 32'(frame_tick), 32'h1);
                brightness = 4'd15;
            end
        end
        for (int s = 0; s < 4; s++) chk($sformatf("f3_slot%0d_lit", s), 32'(slot_lit[s]), 32'd4);
        chk("f3_seg_all_on", 32'(nseg), 32'd0);

        nlit = 0; nseg = 0;
        for (int i = 384; i < 512; i++) begin
            @(negedge clk);
            if (dig_n !== 4'hF) begin
                nlit++;
                if (seg_n !== 8'hFF) nseg++;
            end
            if (i == 424) data_in = 32'h000000FF;
            if (i == 511) chk("f4_tick", 32'(frame_tick), 32'h1);
        end
        chk("f4_lit_cycles", 32'(nlit), 32'd104);
        chk("f4_no_early_data", 32'(nseg), 32'd0);

        for (int i = 512; i < 523; i++) begin
            @(negedge clk);
            if (i == 516) begin
                chk("f5_d0_dig", 32'(dig_n), 32'hE);
                chk("f5_d0_seg", 32'(seg_n), 32'h00);
            end
            if (i == 522) begin
                chk("f5_lit_before_disable", 32'(dig_n), 32'hE);
                enable = 1'b0;
            end
        end
        @(negedge clk);
        chk("dis_dig", 32'(dig_n), 32'hF);
        chk("dis_seg", 32'(seg_n), 32'hFF);
        chk("dis_tick", 32'(frame_tick), 32'h0);
        data_in = 32'h3F3F3F3F;
        @(negedge clk);
        enable = 1'b1;

        ntick = 0;
        for (int j = 0; j < 165; j++) begin
            @(negedge clk);
            if (j < 127 && frame_tick === 1'b1) ntick++;
            if (j == 3) chk("en_pcnt3_dark", 32'(dig_n), 32'hF);
            if (j == 4) begin
                chk("en_d0_dig", 32'(dig_n), 32'hE);
                chk("en_d0_seg", 32'(seg_n), 32'hC0);
            end
            if (j == 127) chk("en_tick", 32'(frame_tick), 32'h1);
            if (j == 164) begin
                chk("pre_reset_dig", 32'(dig_n), 32'hD);
                chk("pre_reset_seg", 32'(seg_n), 32'hC0);
                #2;
                reset_n = 1'b0;
                #1;
                chk("async_reset_seg", 32'(seg_n), 32'hFF);
                chk("async_reset_dig", 32'(dig_n), 32'hF);
            end
        end
        chk("en_no_early_tick", 32'(ntick), 32'd0);

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nlit = 0; ntick = 0;
        for (int k = 0; k < 133; k++) begin
            @(negedge clk);
            if (k < 127) begin
                if (seg_n !== 8'hFF) nlit++;
                if (frame_tick === 1'b1) ntick++;
            end
            if (k == 127) chk("rst_tick_at_128", 32'(frame_tick), 32'h1);
            if (k == 132) begin
                chk("rst_d0_dig", 32'(dig_n), 32'hE);
                chk("rst_d0_seg", 32'(seg_n), 32'hC0);
            end
        end
        chk("rst_frame1_dark", 32'(nlit), 32'd0);
        chk("rst_no_early_tick", 32'(ntick), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
